shift_add_mult: RTL and testbench

Iterative 32x32 shift-and-add multiplier producing a 64-bit product split into lower and higher 32-bit words, for use as the multiply unit behind the datapath's ALU control code. Signed multiply uses magnitude multiplication with a final sign correction; unsigned multiply is also supported. Internal datapath values are exported on debug ports for waveform and monitor inspection.

---
 rtl/shift_add_mult.sv | 148 ++++++++++++++
 tb/tb_shift_add_mult.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
// Iterative 32x32 shift-and-add multiplier.
// Signed operands are reduced to magnitudes at load time, so the iteration
// loop is purely unsigned. The sign is reapplied as a 64-bit negate on the
// final write. One product takes 34 cycles: load, 32 iterations, write-back.
module shift_add_mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  ctrl,
    output logic [31:0] lower,
    output logic [31:0] higher,
    output logic        showin,
    output logic        showout,
    output logic        showadd,
    output logic [31:0] showmult,
    output logic [31:0] showacc,
    output logic [4:0]  showcount,
    output logic [31:0] mshift,
    output logic [31:0] ashift,
    output logic [31:0] showtemp,
    output logic [31:0] showpart
);

    localparam logic [4:0] OP_MULT  = 5'd8;
    localparam logic [4:0] OP_MULTU = 5'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] lower_q, lower_d;
    logic [31:0] higher_q, higher_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mult_q, mult_d;
    logic [31:0] mcand_q, mcand_d;
    logic [4:0]  count_q, count_d;
    logic        neg_q, neg_d;

    logic        is_op;
    logic        is_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] part;
    logic [32:0] sum;
    logic [31:0] acc_shift;
    logic [31:0] mult_shift;
    logic [63:0] prod;
    logic [63:0] prod_fix;

    // Datapath: operand magnitudes, partial product, adder and shifted values.
    // |0x80000000| negates to itself, which is the right unsigned magnitude.
    always_comb begin
        is_op      = (ctrl == OP_MULT) || (ctrl == OP_MULTU);
        is_signed  = (ctrl == OP_MULT);
        a_mag      = (is_signed && a[31]) ? (~a + 32'd1) : a;
        b_mag      = (is_signed && b[31]) ? (~b + 32'd1) : b;
        part       = mcand_q & {32{mult_q[0]}};
        sum        = {1'b0, acc_q} + {1'b0, part};
        acc_shift  = sum[32:1];
        mult_shift = {sum[0], mult_q[31:1]};
        prod       = {acc_q, mult_q};
        prod_fix   = neg_q ? (~prod + 64'd1) : prod;
    end

    // Next-state and register updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d  = state_q;
        lower_d  = lower_q;
        higher_d = higher_q;
        acc_d    = acc_q;
        mult_d   = mult_q;
        mcand_d  = mcand_q;
        count_d  = count_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (is_op) begin
                    mcand_d = a_mag;
                    mult_d  = b_mag;
                    acc_d   = 32'd0;
                    count_d = 5'd0;
                    neg_d   = is_signed & (a[31] ^ b[31]);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_shift;
                mult_d  = mult_shift;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                higher_d = prod_fix[63:32];
                lower_d  = prod_fix[31:0];
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lower_q  <= 32'd0;
            higher_q <= 32'd0;
            acc_q    <= 32'd0;
            mult_q   <= 32'd0;
            mcand_q  <= 32'd0;
            count_q  <= 5'd0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lower_q  <= lower_d;
            higher_q <= higher_d;
            acc_q    <= acc_d;
            mult_q   <= mult_d;
            mcand_q  <= mcand_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
        end
    end

    // Observation ports; shift previews show the live registers outside RUN.
    always_comb begin
        lower     = lower_q;
        higher    = higher_q;
        showin    = (state_q == IDLE) && is_op;
        showout   = (state_q == DONE);
        showadd   = (state_q == RUN) && mult_q[0];
        showmult  = mult_q;
        showacc   = acc_q;
        showcount = count_q;
        mshift    = (state_q == RUN) ? mult_shift : mult_q;
        ashift    = (state_q == RUN) ? acc_shift : acc_q;
        showtemp  = sum[31:0];
        showpart  = part;
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized bench for shift_add_mult against a plain-arithmetic product model.
module tb_shift_add_mult;

    logic        clk;
    logic        rst_n;
    logic [31:0] a, b;
    logic [4:0]  ctrl;
    logic [31:0] lower, higher;
    logic        showin, showout, showadd;
    logic [31:0] showmult, showacc;
    logic [4:0]  showcount;
    logic [31:0] mshift, ashift, showtemp, showpart;

    int          n_chk;
    int          n_fail;
    logic [63:0] last_res;

    shift_add_mult dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ctrl(ctrl),
        .lower(lower), .higher(higher),
        .showin(showin), .showout(showout), .showadd(showadd),
        .showmult(showmult), .showacc(showacc), .showcount(showcount),
        .mshift(mshift), .ashift(ashift), .showtemp(showtemp), .showpart(showpart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Full-width reference product using native 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] c);
        longint      sx, sy;
        logic [63:0] ux, uy;
        if (c == 5'd8) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'h0, x};
        uy = {32'h0, y};
        return ux * uy;
    endfunction

    // One complete operation: load edge, 32 iterations, write-back edge.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [4:0] tc, input bit hold);
        logic [63:0] expv;
        logic [31:0] mb;
        expv = model(ta, tb_v, tc);
        mb   = tb_v;
        if (tc == 5'd8 && tb_v[31]) mb = 32'd0 - tb_v;
        @(negedge clk);
        a = ta; b = tb_v; ctrl = tc;
        #1;
        chk("showin_idle", 64'(showin), 64'd1);
        @(posedge clk); #1;
        if (!hold) begin
            ctrl = 5'($urandom_range(0, 31));
            a    = $urandom;
            b    = $urandom;
        end
        for (int i = 0; i < 32; i++) begin
            chk("run_count", 64'(showcount), 64'(i));
            chk("run_add", 64'(showadd), 64'(mb[i]));
            if (i == 0 || i == 31) chk("run_hold_res", {higher, lower}, last_res);
            @(posedge clk); #1;
        end
        chk("done_showout", 64'(showout), 64'd1);
        chk("done_hold_res", {higher, lower}, last_res);
        @(posedge clk); #1;
        chk("result", {higher, lower}, expv);
        chk("post_showout", 64'(showout), 64'd0);
        last_res = expv;
    endtask

    logic [31:0] ra, rb;
    logic [4:0]  rc;

    initial begin
        n_chk = 0; n_fail = 0; last_res = 64'd0;
        rst_n = 1'b0; a = 32'd0; b = 32'd0; ctrl = 5'd0;
        repeat (2) @(negedge clk);
        chk("rst_result", {higher, lower}, 64'd0);
        chk("rst_count", 64'(showcount), 64'd0);
        chk("rst_acc", {showacc, showmult}, 64'd0);
        chk("rst_shift", {ashift, mshift}, 64'd0);
        chk("rst_flags", {61'd0, showin, showout, showadd}, 64'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op(32'd16, 32'd3, 5'd8, 1'b1);
        run_op(32'hFFFF_FFF9, 32'd6, 5'd8, 1'b0);
        chk("neg42", {higher, lower}, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
        chk("multu_max", {higher, lower}, 64'hFFFF_FFFE_0000_0001);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0);
        chk("mult_m1", {higher, lower}, 64'h0000_0000_0000_0001);
        run_op(32'h8000_0000, 32'h8000_0000, 5'd8, 1'b0);
        chk("mult_min", {higher, lower}, 64'h4000_0000_0000_0000);
        run_op(32'h8000_0000, 32'd1, 5'd8, 1'b1);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 5'd8, 1'b0);
        run_op(32'd0, 32'hDEAD_BEEF, 5'd9, 1'b0);

        // No-op codes leave the block idle with the result held
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            ctrl = (i < 20) ? 5'd0 : ((i % 2 == 0) ? 5'd7 : 5'd31);
            a = $urandom; b = $urandom;
            #1;
            if (i % 8 == 0) begin
                chk("nop_showin", 64'(showin), 64'd0);
                chk("nop_flags", {62'd0, showout, showadd}, 64'd0);
                chk("nop_hold", {higher, lower}, last_res);
            end
            @(negedge clk);
        end

        // Randomized operations, some back-to-back with held inputs
        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = $urandom;
            rc = ($urandom_range(0, 1) == 0) ? 5'd8 : 5'd9;
            if (k % 5 == 0) rb = {rb[31], 31'd0};
            run_op(ra, rb, rc, 1'(k % 3 == 0));
        end

        // Reset in the middle of an iteration sequence
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; ctrl = 5'd8;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_count", 64'(showcount), 64'd10);
        rst_n = 1'b0; ctrl = 5'd0;
        #1;
        chk("mid_rst_result", {higher, lower}, 64'd0);
        chk("mid_rst_count", 64'(showcount), 64'd0);
        chk("mid_rst_regs", {showacc, showmult}, 64'd0);
        chk("mid_rst_flags", {61'd0, showin, showout, showadd}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = 64'd0;
        run_op(32'd5, 32'd5, 5'd8, 1'b1);
        chk("after_rst_25", {higher, lower}, 64'd25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
